sseg_scan_decoder: RTL
======================

Name: sseg_scan_decoder

Overview:
Receive-side counterpart of the calculator's multiplexed seven-segment driver. Monitors the anode and cathode lines and tracks the scan. Reconstructs the four displayed hex digits plus per-digit blank and error flags, then publishes them as one frame. Used in the bench as a self-checking display monitor, and on-chip as a loopback checker for the display path.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (min 2)
TIMEOUT_CYCLES, 1048576, cycles without a completed frame before stale_o asserts

Ports:
clk  input  1  system clock; all logic rising-edge
rst_n  input  1  asynchronous, active-low reset
sseg_a_i  input  4  anode lines, active-low, bit n selects digit n
sseg_c_i  input  7  cathode lines, active-low, {g,f,e,d,c,b,a}, bit0 = a
digits_o  output  16  captured frame, digit n at [4n+3:4n]
blank_o  output  4  digit n was blank (cathodes 7'h7F)
err_o  output  4  digit n had an undecodable cathode pattern
frame_valid_o  output  1  one-cycle pulse when digits_o/blank_o/err_o update
stale_o  output  1  no frame completed within TIMEOUT_CYCLES

Behaviour:
- Reset (async assert, sync release): all outputs 0, sample regs 7'h7F/4'hF, stable counter 0, seen mask 0, timeout counter 0, FSM = SETTLE.
- Every edge: sseg_a_i/sseg_c_i registered into s_an/s_cat. Stable counter cleared when the new sample differs from s_an/s_cat. Otherwise it increments, saturating at STABLE_CYCLES-1.
- Anode valid only when exactly one bit is 0. Invalid anode holds FSM in SETTLE and captures nothing.
- FSM SETTLE: on the edge where the counter is STABLE_CYCLES-1 and the anode is valid, capture the digit into working slot n, set seen[n], and go to HELD. Capture happens STABLE_CYCLES edges after the input change, counting the sampling edge as the first.
- FSM HELD: no further capture. Return to SETTLE on the first edge where the sample changes.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex of 7-bit pattern)
  - 7F: nibble 0, blank bit set.
  - Any other pattern: nibble 0, err bit set.
- Re-capturing an already-seen digit before the frame completes overwrites its slot. This is not an error.
- Frame completion: on the capture edge that makes seen == 4'hF:
  - digits_o/blank_o/err_o load the working slots, including the digit captured on that edge.
  - frame_valid_o = 1 for exactly that cycle.
  - seen clears.
- Timeout counter increments each cycle and clears on frame completion. stale_o sets when the counter reaches TIMEOUT_CYCLES and stays set. stale_o clears on the frame_valid_o edge; the counter saturates.
- Outputs hold their last frame between pulses.
- Reset mid-dwell or mid-frame discards partial captures; no frame_valid_o is produced.

Test Plan:
(All tests: STABLE_CYCLES=4, TIMEOUT_CYCLES=64.)
- Scan digits 0..3 at 8 cycles each: a=1110/c=30, a=1101/c=40, a=1011/c=40, a=0111/c=40 -> single frame_valid_o pulse on the 4th capture edge; digits_o=16'h0003, blank_o=0, err_o=0.
- Same scan but digit 2 dwells only 3 cycles, then the full scan repeats -> no pulse in the first pass; pulse after the second pass with 16'h0003.
- Drive a=1100 (two anodes) and a=1111 for 10 cycles each, interleaved with a valid scan -> invalid intervals ignored; frame still 16'h0003.
- Digit0 cathode 55, digits 1..3 cathode 7F -> digits_o=16'h0000, err_o=4'b0001, blank_o=4'b1110.
- Scan F,E,d,C (c=0E,06,21,46 on digits 3..0), then hold inputs static for 70 cycles -> digits_o=16'hFEDC; stale_o rises 64 cycles after the pulse; a new scan clears stale_o with the next pulse.
- Pull rst_n low for 2 cycles after 3 digits are captured -> all outputs 0 immediately; the next pulse requires all 4 digits to be re-captured.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Watches a multiplexed, active-low seven-segment scan and rebuilds the four
// displayed hex digits, with per-digit blank/error flags, as one frame.
//
// state  | meaning
// SETTLE | waiting for a valid anode/cathode sample to stay stable long enough
// HELD   | digit captured; ignore the dwell until the sample changes again
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sseg_a_i,
  input  logic [6:0]  sseg_c_i,
  output logic [15:0] digits_o,
  output logic [3:0]  blank_o,
  output logic [3:0]  err_o,
  output logic        frame_valid_o,
  output logic        stale_o
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic {SETTLE, HELD} state_t;

  state_t        state, state_nxt;
  logic [3:0]    s_an;
  logic [6:0]    s_cat;
  logic [CW-1:0] stab_cnt, stab_cnt_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [15:0]   w_dig, dig_m;
  logic [3:0]    w_blank, w_err, seen;
  logic [3:0]    blank_m, err_m, seen_m, sel;
  logic          same, an_valid, capture, frame_done;
  logic [5:0]    dec;

  // Returns {err, blank, nibble} for an active-low {g..a} cathode pattern.
  function automatic logic [5:0] decode(input logic [6:0] c);
    case (c)
      7'h40:   decode = 6'h00;
      7'h79:   decode = 6'h01;
      7'h24:   decode = 6'h02;
      7'h30:   decode = 6'h03;
      7'h19:   decode = 6'h04;
      7'h12:   decode = 6'h05;
      7'h02:   decode = 6'h06;
      7'h78:   decode = 6'h07;
      7'h00:   decode = 6'h08;
      7'h10:   decode = 6'h09;
      7'h08:   decode = 6'h0A;
      7'h03:   decode = 6'h0B;
      7'h46:   decode = 6'h0C;
      7'h21:   decode = 6'h0D;
      7'h06:   decode = 6'h0E;
      7'h0E:   decode = 6'h0F;
      7'h7F:   decode = 6'h10;
      default: decode = 6'h20;
    endcase
  endfunction

  always_comb begin
    same         = (sseg_a_i == s_an) && (sseg_c_i == s_cat);
    stab_cnt_nxt = '0;
    if (same) stab_cnt_nxt = (stab_cnt == CNT_MAX) ? CNT_MAX : stab_cnt + CW'(1);

    sel = 4'h0;
    case (s_an)
      4'b1110: sel = 4'b0001;
      4'b1101: sel = 4'b0010;
      4'b1011: sel = 4'b0100;
      4'b0111: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    an_valid = (sel != 4'h0);

    // Capture on the edge where the counter reaches its terminal value.
    capture = (state == SETTLE) && same && an_valid && (stab_cnt_nxt == CNT_MAX);

    dec     = decode(s_cat);
    dig_m   = w_dig;
    blank_m = w_blank;
    err_m   = w_err;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        dig_m[4*i +: 4] = dec[3:0];
        blank_m[i]      = dec[4];
        err_m[i]        = dec[5];
      end
    end
    seen_m     = seen | sel;
    frame_done = capture && (seen_m == 4'hF);

    tmo_cnt_nxt = '0;
    if (!frame_done) tmo_cnt_nxt = (tmo_cnt == TMO_MAX) ? TMO_MAX : tmo_cnt + TW'(1);

    state_nxt = state;
    case (state)
      SETTLE:  if (capture) state_nxt = HELD;
      HELD:    if (!same) state_nxt = SETTLE;
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SETTLE;
      s_an          <= 4'hF;
      s_cat         <= 7'h7F;
      stab_cnt      <= '0;
      tmo_cnt       <= '0;
      w_dig         <= '0;
      w_blank       <= '0;
      w_err         <= '0;
      seen          <= '0;
      digits_o      <= '0;
      blank_o       <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
      stale_o       <= 1'b0;
    end else begin
      state         <= state_nxt;
      s_an          <= sseg_a_i;
      s_cat         <= sseg_c_i;
      stab_cnt      <= stab_cnt_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
      frame_valid_o <= frame_done;
      if (capture) begin
        w_dig   <= dig_m;
        w_blank <= blank_m;
        w_err   <= err_m;
        seen    <= frame_done ? 4'h0 : seen_m;
      end
      if (frame_done) begin
        digits_o <= dig_m;
        blank_o  <= blank_m;
        err_o    <= err_m;
        stale_o  <= 1'b0;
      end else if (tmo_cnt_nxt == TMO_MAX) begin
        stale_o  <= 1'b1;
      end
    end
  end

endmodule
